ghost_ram_rd_arbiter: RTL and testbench
=======================================

// Module: ghost_ram_rd_arbiter
// PURPOSE
//  Shares the single read port of the ghost proximity RAM (ghost_RAM_ctrl) among NUM_REQ requesters.
//  Typical requesters: per-ghost path finders and the collision/scatter logic.
//  Round-robin arbitration; one read issued per cycle max; pipelined, in-order responses tagged one-hot.
//  Off-map coordinates never reach the RAM and return WALL_VAL.
// PARAMETERS
//  NUM_REQ   4      number of requesters (2..8)
//  RD_LAT    1      RAM read latency: ram_data valid RD_LAT cycles after rdaddr_x/y presented (1..3)
//  MAP_W     40     valid x range 0..MAP_W-1
//  MAP_H     30     valid y range 0..MAP_H-1
//  WALL_VAL  8'hFF  response value for off-map addresses
// PORTS
//  CLOCK_50   in   1          system clock, all logic on posedge
//  reset      in   1          synchronous, active-high
//  req        in   NUM_REQ    request per requester; held with stable address until gnt
//  req_x      in   6*NUM_REQ  x address, requester i at [6i+5:6i]
//  req_y      in   5*NUM_REQ  y address, requester i at [5i+4:5i]
//  gnt        out  NUM_REQ    one-hot, combinational; high in the cycle the request is accepted
//  ram_ready  in   1          RAM map valid (ghost_RAM_ctrl.ready); no grants while low
//  rdaddr_x   out  6          registered RAM read address x
//  rdaddr_y   out  5          registered RAM read address y
//  ram_data   in   8          RAM read data
//  rsp_valid  out  NUM_REQ    one-hot, registered, one-cycle pulse per granted request
//  rsp_data   out  8          proximity value for the rsp_valid requester
//  busy       out  1          any request in flight
// BEHAVIOUR
//  Reset values
//   - gnt=0, rsp_valid=0, rsp_data=0, rdaddr_x=0, rdaddr_y=0, busy=0.
//   - RR pointer=0 (requester 0 highest priority); in-flight pipeline cleared.
//  Arbitration
//   - Candidates = req & {NUM_REQ{ram_ready}}.
//   - Winner is the first set bit searching from ptr upward, with wrap-around.
//   - gnt[winner]=1 that cycle; ptr <= winner+1 (mod NUM_REQ) at the edge.
//   - ptr is unchanged when nothing is granted.
//   - Back-to-back grants are allowed, including to the same requester if it is the only one requesting.
//   - A requester that drops req before gnt is simply skipped; no error.
//  Timing
//   - Grant in cycle T: the address is sampled at the end of T.
//   - Valid address: rdaddr_x/y presented during T+1.
//   - Data: ram_data sampled at the end of T+RD_LAT.
//   - Response: rsp_valid/rsp_data during T+RD_LAT+1. Grant-to-response = RD_LAT+1 cycles.
//   - rdaddr_x/y hold their last value when no grant occurs.
//  Tag pipeline
//   - RD_LAT+1 stages, each {valid, one-hot id, offmap}.
//   - Responses are strictly in grant order; one response per grant.
//   - busy = OR of stage valids.
//  Off-map handling
//   - Applies when req_x >= MAP_W or req_y >= MAP_H (covers 0-1 underflow to 63/31).
//   - The access is granted normally, but rdaddr is not updated and the RAM is not read.
//   - rsp_data = WALL_VAL with the same latency, so a minimum search never selects it.
//  ram_ready
//   - Falling while requests are in flight does not cancel them; they complete with RAM data.
//  Reset mid-operation
//   - All stages are cleared; no rsp_valid is produced for pre-reset grants.
//  Widths
//   - Bounds compares are unsigned, at the port widths. No arithmetic is applied to addresses.
// STRUCTURE
//  Package ghost_map_pkg
//   - MAP_W, MAP_H, COORD_X_W=6, COORD_Y_W=5, PROX_W=8, WALL_VAL.
//   - typedef coord_t {x,y}; typedef rd_tag_t {valid, id, offmap}.
//  Sub-module rr_arbiter #(N)
//   - Combinational: (req, ptr) -> one-hot gnt, winner index.
//   - Pointer register and tag pipeline stay in ghost_ram_rd_arbiter.
// TESTING
//  1. Single requester:
//     - Stimulus: reset, ram_ready=1, req=0001, addr (16,12), RAM returns 8'd7.
//     - Response: gnt=0001 in T; rdaddr=(16,12) in T+1; rsp_valid=0001, rsp_data=7 in T+2 (RD_LAT=1).
//  2. All four requesting continuously for 8 cycles:
//     - Response: grant order 0,1,2,3,0,1,2,3; one gnt per cycle.
//     - Eight responses in the same order, each 2 cycles after its gnt.
//  3. Off-map:
//     - Stimulus: req1 with x=63 (from 0-1), req2 with y=30.
//     - Response: both granted; rdaddr unchanged; rsp_data=8'hFF for each, with normal latency.
//  4. ram_ready gating:
//     - Stimulus: ram_ready=0 with req=1111 for 5 cycles.
//     - Response: gnt=0, busy=0. Then ram_ready=1: first gnt to requester 0 (or ptr) in the same cycle.
//  5. Reset mid-flight:
//     - Stimulus: grant in T, reset asserted in T+1.
//     - Response: no rsp_valid in T+2 or later; ptr=0; busy=0 from T+2.
//  6. Fairness under load:
//     - Stimulus: requester 3 held; requesters 0..2 toggle randomly for 1000 cycles.
//     - Response: requester 3 waits at most NUM_REQ-1 cycles between grants. Scoreboard matches every rsp to its gnt.

Source files
------------

// File: rtl/ghost_map_pkg.sv
// Shared map geometry, coordinate/tag types and the off-map test used by
// the ghost RAM read arbiter.
package ghost_map_pkg;

  localparam int unsigned MAP_W     = 40;
  localparam int unsigned MAP_H     = 30;
  localparam int unsigned COORD_X_W = 6;
  localparam int unsigned COORD_Y_W = 5;
  localparam int unsigned PROX_W    = 8;
  localparam int unsigned MAX_REQ   = 8;

  localparam logic [PROX_W-1:0] WALL_VAL = 8'hFF;

  typedef struct packed {
    logic [COORD_X_W-1:0] x;
    logic [COORD_Y_W-1:0] y;
  } coord_t;

  typedef struct packed {
    logic               valid;
    logic [MAX_REQ-1:0] id;
    logic               offmap;
  } rd_tag_t;

  // Unsigned compare at port width, so 0-1 underflow (63/31) lands off-map.
  function automatic logic is_offmap(coord_t c, int unsigned w, int unsigned h);
    return (32'(c.x) >= w) || (32'(c.y) >= h);
  endfunction

endpackage

// File: rtl/ghost_ram_rd_arbiter_if.sv
// Requester and RAM-side signal bundle for the ghost RAM read arbiter.
interface ghost_ram_rd_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  import ghost_map_pkg::*;

  logic [NUM_REQ-1:0]           req;
  logic [COORD_X_W*NUM_REQ-1:0] req_x;
  logic [COORD_Y_W*NUM_REQ-1:0] req_y;
  logic [NUM_REQ-1:0]           gnt;
  logic                         ram_ready;
  logic [COORD_X_W-1:0]         rdaddr_x;
  logic [COORD_Y_W-1:0]         rdaddr_y;
  logic [PROX_W-1:0]            ram_data;
  logic [NUM_REQ-1:0]           rsp_valid;
  logic [PROX_W-1:0]            rsp_data;
  logic                         busy;

  modport slave (
    input  req, req_x, req_y, ram_ready, ram_data,
    output gnt, rdaddr_x, rdaddr_y, rsp_valid, rsp_data, busy
  );

  modport master (
    output req, req_x, req_y, ram_ready, ram_data,
    input  gnt, rdaddr_x, rdaddr_y, rsp_valid, rsp_data, busy
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic [N-1:0] o_gnt,
  output logic [W-1:0] o_idx,
  output logic         o_any
);

  int unsigned w_j;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_j   = 0;
    for (int unsigned k = 0; k < N; k++) begin
      w_j = (32'(i_ptr) + k) % N;
      if (!o_any && i_req[w_j[W-1:0]]) begin
        o_any            = 1'b1;
        o_idx            = w_j[W-1:0];
        o_gnt[w_j[W-1:0]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ghost_ram_rd_arbiter.sv
// Shares the ghost proximity RAM read port among NUM_REQ requesters with
// round-robin grants and in-order, one-hot tagged responses.
module ghost_ram_rd_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned RD_LAT  = 1,
  parameter int unsigned MAP_W   = ghost_map_pkg::MAP_W,
  parameter int unsigned MAP_H   = ghost_map_pkg::MAP_H,
  parameter logic [ghost_map_pkg::PROX_W-1:0] WALL_VAL = ghost_map_pkg::WALL_VAL
) (
  input logic                   CLOCK_50,
  input logic                   reset,
  ghost_ram_rd_arbiter_if.slave bus
);
  import ghost_map_pkg::*;

  localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0]        r_ptr;
  logic [PW-1:0]        w_idx;
  logic [NUM_REQ-1:0]   w_cand;
  logic [NUM_REQ-1:0]   w_gnt;
  logic                 w_any;
  coord_t               w_sel;
  logic                 w_offmap;
  rd_tag_t              w_new_tag;
  logic                 w_busy;

  rd_tag_t              r_tag [RD_LAT];
  logic [NUM_REQ-1:0]   r_rsp_valid;
  logic [PROX_W-1:0]    r_rsp_data;
  logic [COORD_X_W-1:0] r_rdaddr_x;
  logic [COORD_Y_W-1:0] r_rdaddr_y;

  // Reset also masks candidates so gnt reads zero during reset.
  assign w_cand = bus.req & {NUM_REQ{bus.ram_ready & ~reset}};

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .i_req (w_cand),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  always_comb begin
    w_sel.x          = bus.req_x[COORD_X_W*w_idx +: COORD_X_W];
    w_sel.y          = bus.req_y[COORD_Y_W*w_idx +: COORD_Y_W];
    w_offmap         = is_offmap(w_sel, MAP_W, MAP_H);
    w_new_tag.valid  = w_any;
    w_new_tag.id     = MAX_REQ'(w_gnt);
    w_new_tag.offmap = w_offmap;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_ptr       <= '0;
      r_rdaddr_x  <= '0;
      r_rdaddr_y  <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      for (int unsigned k = 0; k < RD_LAT; k++) r_tag[k] <= '0;
    end else begin
      if (w_any) r_ptr <= (32'(w_idx) == NUM_REQ - 1) ? '0 : w_idx + 1'b1;
      // Off-map grants leave the RAM address alone; the tag carries WALL_VAL.
      if (w_any && !w_offmap) begin
        r_rdaddr_x <= w_sel.x;
        r_rdaddr_y <= w_sel.y;
      end
      r_tag[0] <= w_new_tag;
      for (int unsigned k = 1; k < RD_LAT; k++) r_tag[k] <= r_tag[k-1];
      r_rsp_valid <= r_tag[RD_LAT-1].valid ? r_tag[RD_LAT-1].id[NUM_REQ-1:0] : '0;
      if (r_tag[RD_LAT-1].valid)
        r_rsp_data <= r_tag[RD_LAT-1].offmap ? WALL_VAL : bus.ram_data;
    end
  end

  always_comb begin
    w_busy = |r_rsp_valid;
    for (int unsigned k = 0; k < RD_LAT; k++) w_busy = w_busy | r_tag[k].valid;
  end

  assign bus.gnt       = w_gnt;
  assign bus.rdaddr_x  = r_rdaddr_x;
  assign bus.rdaddr_y  = r_rdaddr_y;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.busy      = w_busy;

endmodule

// File: tb/tb_ghost_ram_rd_arbiter.sv
// Bench for ghost_ram_rd_arbiter: scenario tasks checked against a
// queue-based model of grants and their expected responses.
module tb_ghost_ram_rd_arbiter;

  localparam int NUM_REQ = 4;
  localparam int RD_LAT  = 1;

  logic clk = 1'b0;
  logic reset;
  always #10 clk = ~clk;

  ghost_ram_rd_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  ghost_ram_rd_arbiter #(.NUM_REQ(NUM_REQ), .RD_LAT(RD_LAT)) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .bus      (bus)
  );

  logic [7:0] mem [64][32];
  always_comb bus.ram_data = mem[bus.rdaddr_x][bus.rdaddr_y];

  typedef struct {
    int         due;
    int         id;
    logic [7:0] data;
  } exp_rsp_t;

  exp_rsp_t   q[$];
  int         m_ptr, cyc, exp_win;
  logic [5:0] m_rdx;
  logic [4:0] m_rdy;
  logic [3:0] exp_gnt, exp_rv;
  logic [7:0] exp_rd;
  logic       exp_busy;
  int         n_cmp = 0;
  int         n_bad = 0;

  function automatic void model_eval();
    exp_gnt = '0;
    exp_win = -1;
    if (!reset && bus.ram_ready === 1'b1)
      for (int k = 0; k < NUM_REQ; k++) begin
        int j;
        j = (m_ptr + k) % NUM_REQ;
        if (exp_win < 0 && bus.req[j]) exp_win = j;
      end
    if (exp_win >= 0) exp_gnt[exp_win] = 1'b1;
    exp_busy = (q.size() != 0);
    exp_rv   = '0;
    exp_rd   = '0;
    if (q.size() != 0 && q[0].due == cyc) begin
      exp_rv[q[0].id] = 1'b1;
      exp_rd          = q[0].data;
    end
  endfunction

  function automatic void model_commit();
    if (reset) begin
      q.delete();
      m_ptr = 0;
      m_rdx = '0;
      m_rdy = '0;
    end else begin
      if (q.size() != 0 && q[0].due == cyc) void'(q.pop_front());
      if (exp_win >= 0) begin
        logic [5:0] x;
        logic [4:0] y;
        bit         off;
        exp_rsp_t   e;
        x      = bus.req_x[6*exp_win +: 6];
        y      = bus.req_y[5*exp_win +: 5];
        off    = (x >= 6'd40) || (y >= 5'd30);
        e.due  = cyc + RD_LAT + 1;
        e.id   = exp_win;
        e.data = off ? 8'hFF : mem[x][y];
        if (!off) begin
          m_rdx = x;
          m_rdy = y;
        end
        q.push_back(e);
        m_ptr = (exp_win + 1) % NUM_REQ;
      end
    end
    cyc++;
  endfunction

  task automatic sample();
    @(negedge clk);
    model_eval();
  endtask

  task automatic advance();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      sample();
      advance();
    end
  endtask

  task automatic set_addr(input int i, input logic [5:0] x, input logic [4:0] y);
    bus.req_x[6*i +: 6] = x;
    bus.req_y[5*i +: 5] = y;
  endtask

  task automatic new_addr(input int i, input bit allow_off);
    if (allow_off && $urandom_range(0, 3) == 0)
      set_addr(i, 6'($urandom), 5'($urandom));
    else
      set_addr(i, 6'($urandom_range(0, 39)), 5'($urandom_range(0, 29)));
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.ram_ready = 1'b1;
    bus.req = '1;
    for (int i = 0; i < NUM_REQ; i++) new_addr(i, 1'b0);
    idle(2);
    sample();
    n_cmp++; if (bus.gnt !== 4'b0) begin n_bad++; $display("FAIL reset_gnt got %b want 0000", bus.gnt); end
    n_cmp++; if (bus.rsp_valid !== 4'b0) begin n_bad++; $display("FAIL reset_rsp_valid got %b want 0000", bus.rsp_valid); end
    n_cmp++; if (bus.rsp_data !== 8'h00) begin n_bad++; $display("FAIL reset_rsp_data got %h want 00", bus.rsp_data); end
    n_cmp++; if ({bus.rdaddr_x, bus.rdaddr_y} !== 11'd0) begin n_bad++; $display("FAIL reset_rdaddr got (%0d,%0d) want (0,0)", bus.rdaddr_x, bus.rdaddr_y); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    advance();
    reset = 1'b0;
    bus.req = '0;
  endtask

  task automatic test_single();
    bus.ram_ready = 1'b1;
    bus.req = 4'b0001;
    set_addr(0, 6'd16, 5'd12);
    sample();
    n_cmp++; if (bus.gnt !== 4'b0001) begin n_bad++; $display("FAIL single_gnt got %b want 0001", bus.gnt); end
    advance();
    bus.req = '0;
    sample();
    n_cmp++; if ({bus.rdaddr_x, bus.rdaddr_y} !== {6'd16, 5'd12}) begin n_bad++; $display("FAIL single_rdaddr got (%0d,%0d) want (16,12)", bus.rdaddr_x, bus.rdaddr_y); end
    n_cmp++; if (bus.rsp_valid !== 4'b0) begin n_bad++; $display("FAIL single_early_rsp got %b want 0000", bus.rsp_valid); end
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL single_busy got %b want 1", bus.busy); end
    advance();
    sample();
    n_cmp++; if (bus.rsp_valid !== 4'b0001) begin n_bad++; $display("FAIL single_rsp_valid got %b want 0001", bus.rsp_valid); end
    n_cmp++; if (bus.rsp_data !== 8'd7) begin n_bad++; $display("FAIL single_rsp_data got %0d want 7", bus.rsp_data); end
    advance();
    sample();
    n_cmp++; if (bus.rsp_valid !== 4'b0) begin n_bad++; $display("FAIL single_rsp_pulse got %b want 0000", bus.rsp_valid); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL single_idle_busy got %b want 0", bus.busy); end
    advance();
  endtask

  task automatic test_rr_all();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    bus.ram_ready = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) new_addr(i, 1'b0);
    for (int k = 0; k < 12; k++) begin
      bus.req = (k < 8) ? 4'b1111 : 4'b0000;
      sample();
      if (k < 8) begin
        n_cmp++; if (bus.gnt !== 4'(1 << (k % 4))) begin n_bad++; $display("FAIL rr_order k=%0d got %b want %b", k, bus.gnt, 4'(1 << (k % 4))); end
      end
      n_cmp++; if (bus.gnt !== exp_gnt) begin n_bad++; $display("FAIL rr_gnt k=%0d got %b want %b", k, bus.gnt, exp_gnt); end
      n_cmp++; if (bus.rsp_valid !== exp_rv) begin n_bad++; $display("FAIL rr_rsp_valid k=%0d got %b want %b", k, bus.rsp_valid, exp_rv); end
      if (exp_rv != 4'b0) begin
        n_cmp++; if (bus.rsp_data !== exp_rd) begin n_bad++; $display("FAIL rr_rsp_data k=%0d got %h want %h", k, bus.rsp_data, exp_rd); end
      end
      n_cmp++; if (bus.busy !== exp_busy) begin n_bad++; $display("FAIL rr_busy k=%0d got %b want %b", k, bus.busy, exp_busy); end
      advance();
      if (exp_win >= 0) new_addr(exp_win, 1'b0);
    end
  endtask

  task automatic test_offmap();
    logic [5:0] xm;
    logic [5:0] rx;
    logic [4:0] ry;
    xm = 6'd0 - 6'd1;
    rx = m_rdx;
    ry = m_rdy;
    bus.ram_ready = 1'b1;
    bus.req = 4'b0110;
    set_addr(1, xm, 5'd5);
    set_addr(2, 6'd3, 5'd30);
    sample();
    n_cmp++; if (bus.gnt !== 4'b0010) begin n_bad++; $display("FAIL offmap_gnt1 got %b want 0010", bus.gnt); end
    advance();
    bus.req = 4'b0100;
    sample();
    n_cmp++; if (bus.gnt !== 4'b0100) begin n_bad++; $display("FAIL offmap_gnt2 got %b want 0100", bus.gnt); end
    n_cmp++; if ({bus.rdaddr_x, bus.rdaddr_y} !== {rx, ry}) begin n_bad++; $display("FAIL offmap_rdaddr1 got (%0d,%0d) want (%0d,%0d)", bus.rdaddr_x, bus.rdaddr_y, rx, ry); end
    advance();
    bus.req = '0;
    sample();
    n_cmp++; if (bus.rsp_valid !== 4'b0010) begin n_bad++; $display("FAIL offmap_rsp1 got %b want 0010", bus.rsp_valid); end
    n_cmp++; if (bus.rsp_data !== 8'hFF) begin n_bad++; $display("FAIL offmap_data1 got %h want ff", bus.rsp_data); end
    n_cmp++; if ({bus.rdaddr_x, bus.rdaddr_y} !== {rx, ry}) begin n_bad++; $display("FAIL offmap_rdaddr2 got (%0d,%0d) want (%0d,%0d)", bus.rdaddr_x, bus.rdaddr_y, rx, ry); end
    advance();
    sample();
    n_cmp++; if (bus.rsp_valid !== 4'b0100) begin n_bad++; $display("FAIL offmap_rsp2 got %b want 0100", bus.rsp_valid); end
    n_cmp++; if (bus.rsp_data !== 8'hFF) begin n_bad++; $display("FAIL offmap_data2 got %h want ff", bus.rsp_data); end
    advance();
  endtask

  task automatic test_ready_gating();
    bus.ram_ready = 1'b0;
    bus.req = '1;
    for (int i = 0; i < NUM_REQ; i++) new_addr(i, 1'b0);
    repeat (5) begin
      sample();
      n_cmp++; if (bus.gnt !== 4'b0) begin n_bad++; $display("FAIL gate_gnt got %b want 0000", bus.gnt); end
      n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL gate_busy got %b want 0", bus.busy); end
      advance();
    end
    bus.ram_ready = 1'b1;
    sample();
    n_cmp++; if (bus.gnt !== 4'b1000) begin n_bad++; $display("FAIL gate_first_gnt got %b want 1000", bus.gnt); end
    n_cmp++; if (bus.gnt !== exp_gnt) begin n_bad++; $display("FAIL gate_model_gnt got %b want %b", bus.gnt, exp_gnt); end
    advance();
    bus.ram_ready = 1'b0;
    bus.req = '0;
    sample();
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL gate_inflight_busy got %b want 1", bus.busy); end
    advance();
    sample();
    n_cmp++; if (bus.rsp_valid !== 4'b1000) begin n_bad++; $display("FAIL gate_inflight_rsp got %b want 1000", bus.rsp_valid); end
    n_cmp++; if (bus.rsp_data !== exp_rd) begin n_bad++; $display("FAIL gate_inflight_data got %h want %h", bus.rsp_data, exp_rd); end
    advance();
  endtask

  task automatic test_reset_midflight();
    bus.ram_ready = 1'b1;
    bus.req = 4'b0001;
    new_addr(0, 1'b0);
    sample();
    n_cmp++; if (bus.gnt !== 4'b0001) begin n_bad++; $display("FAIL midrst_gnt got %b want 0001", bus.gnt); end
    advance();
    bus.req = '0;
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    repeat (3) begin
      sample();
      n_cmp++; if (bus.rsp_valid !== 4'b0) begin n_bad++; $display("FAIL midrst_rsp got %b want 0000", bus.rsp_valid); end
      n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy got %b want 0", bus.busy); end
      advance();
    end
    bus.req = '1;
    sample();
    n_cmp++; if (bus.gnt !== 4'b0001) begin n_bad++; $display("FAIL midrst_ptr got %b want 0001", bus.gnt); end
    advance();
    bus.req = '0;
    idle(3);
  endtask

  task automatic test_fairness();
    int last3;
    int maxgap;
    last3  = -1;
    maxgap = 0;
    bus.ram_ready = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) new_addr(i, 1'b1);
    for (int c = 0; c < 1000; c++) begin
      bus.req = {1'b1, 3'($urandom)};
      sample();
      n_cmp++; if (bus.gnt !== exp_gnt) begin n_bad++; $display("FAIL fair_gnt c=%0d got %b want %b", c, bus.gnt, exp_gnt); end
      n_cmp++; if (bus.rsp_valid !== exp_rv) begin n_bad++; $display("FAIL fair_rsp_valid c=%0d got %b want %b", c, bus.rsp_valid, exp_rv); end
      if (exp_rv != 4'b0) begin
        n_cmp++; if (bus.rsp_data !== exp_rd) begin n_bad++; $display("FAIL fair_rsp_data c=%0d got %h want %h", c, bus.rsp_data, exp_rd); end
      end
      n_cmp++; if (bus.busy !== exp_busy) begin n_bad++; $display("FAIL fair_busy c=%0d got %b want %b", c, bus.busy, exp_busy); end
      n_cmp++; if ({bus.rdaddr_x, bus.rdaddr_y} !== {m_rdx, m_rdy}) begin n_bad++; $display("FAIL fair_rdaddr c=%0d got (%0d,%0d) want (%0d,%0d)", c, bus.rdaddr_x, bus.rdaddr_y, m_rdx, m_rdy); end
      if (bus.gnt[3] === 1'b1) begin
        if (last3 >= 0 && c - last3 > maxgap) maxgap = c - last3;
        last3 = c;
      end
      advance();
      if (exp_win >= 0) new_addr(exp_win, 1'b1);
    end
    n_cmp++; if (last3 < 0 || maxgap > NUM_REQ) begin n_bad++; $display("FAIL fair_gap got %0d want <= %0d (last grant %0d)", maxgap, NUM_REQ, last3); end
    bus.req = '0;
    idle(3);
    sample();
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL fair_drain_busy got %b want 0", bus.busy); end
    advance();
  endtask

  initial begin
    reset = 1'b1;
    bus.req = '0;
    bus.req_x = '0;
    bus.req_y = '0;
    bus.ram_ready = 1'b0;
    cyc = 0;
    m_ptr = 0;
    m_rdx = '0;
    m_rdy = '0;
    for (int x = 0; x < 64; x++)
      for (int y = 0; y < 32; y++) mem[x][y] = 8'($urandom_range(0, 254));
    mem[16][12] = 8'd7;

    test_reset();
    test_single();
    test_rr_all();
    test_offmap();
    test_ready_gating();
    test_reset_midflight();
    test_fairness();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
